motor_cmd_sequencer: RTL and testbench
======================================

Name: motor_cmd_sequencer

Overview:
- Sits between the command byte receiver and the H-bridge pins of the car.
- Accepts command bytes over a valid/ready handshake and sequences the drive and steering bridges through independent FSMs.
- Inserts dead time on every polarity reversal and PWM-modulates the drive enable.
- A command watchdog stops the drive motor when the command stream goes silent.

Parameters:
- DEADTIME_CYCLES, 1000: cycles with all pins low between opposite polarities on one bridge; minimum 1.
- WATCHDOG_CYCLES, 5000000: cycles with no accepted command before the drive is forced to stop; minimum 2.
- PWM_BITS, 8: width of the duty input and of the PWM counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_data  in  8  command byte.
- cmd_valid  in  1  cmd_data is valid.
- cmd_ready  out  1  block can accept a command this cycle.
- duty  in  PWM_BITS  drive duty cycle.
- a1, a2  out  1 each  drive bridge polarity.
- m12_en  out  1  drive bridge enable (PWM).
- a3, a4  out  1 each  steering bridge polarity.
- m34_en  out  1  steering bridge enable.
- wd_timeout  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset: drive FSM goes to D_STOP, steering FSM to S_CENTER, all counters to 0. All outputs are 0 except cmd_ready=1.
- Accept: a command is accepted on an edge where cmd_valid and cmd_ready are both 1.
- cmd_ready is 1 unless either FSM is in its DEAD state.
- Command decode:
  - 0xF9: FWD
  - 0x79: REV
  - 0x59: LEFT
  - 0xE9: CENTER
  - 0xB9: RIGHT
  - any other value: STOP. STOP affects the drive only; steering is unchanged.
- Drive FSM states: D_STOP, D_FWD, D_REV, D_DEAD.
  - STOP to FWD or REV: direct.
  - FWD or REV to STOP: direct.
  - FWD to REV, or REV to FWD: enter D_DEAD and latch the target.
  - D_DEAD counts DEADTIME_CYCLES cycles, then enters the latched target.
  - Repeating the current command causes no state change.
- Steering FSM states: S_CENTER, S_LEFT, S_RIGHT, S_DEAD. Same rules as the drive FSM:
  - LEFT to RIGHT and RIGHT to LEFT pass through S_DEAD.
  - Every other transition is direct.
  - Steering has its own dead-time counter.
- Pin encoding ({a1,a2} and {a3,a4}):
  - Drive: FWD=10, REV=01, STOP/DEAD=00.
  - Steering: LEFT=10, RIGHT=01, CENTER/DEAD=00.
  - m34_en = 1 only in S_LEFT and S_RIGHT.
- PWM:
  - A free-running PWM_BITS counter wraps at 2^PWM_BITS-1.
  - duty is sampled into a shadow register when the counter is at 0.
  - In D_FWD and D_REV, m12_en = (cnt < shadow), except shadow = all-ones gives a constant 1.
  - shadow = 0 gives a constant 0.
  - m12_en = 0 in all other drive states.
- Latency: all pin outputs are registered. A command accepted on edge N changes the pins after edge N+1. Dead time on the pins is exactly DEADTIME_CYCLES cycles of 00.
- Watchdog:
  - The counter clears on every accepted command, including repeated or unknown codes.
  - When the counter reaches WATCHDOG_CYCLES-1: the drive goes to D_STOP immediately (also from D_DEAD, discarding the target). wd_timeout pulses for 1 cycle and the counter holds until the next accepted command. Steering is unchanged.
- Simultaneous events: if a command is accepted on the watchdog-expiry edge, the command wins, no timeout fires and the counter clears.
- Reset mid-operation: reset asserted in any state, including DEAD, returns to the reset values asynchronously. No dead time is applied on exit from reset.

Optional Feature:
- MOTOR_BRAKE_EN defined: D_STOP drives a1=1, a2=1, m12_en=1 (active short brake). D_DEAD still drives 000. Reset value stays 000 until the first clock edge after reset deasserts, then shows 111 while in D_STOP.
- Not defined: D_STOP coasts with 000.

Test Plan (DEADTIME_CYCLES=4, WATCHDOG_CYCLES=100, PWM_BITS=4):
- Reset, then 0xF9 with duty=8 -> a1a2=10. m12_en high for 8 of every 16 cycles. cmd_ready stays 1.
- In FWD, send 0x79 -> a1a2=00 and m12_en=0 for exactly 4 cycles, cmd_ready=0 during those cycles, then a1a2=01 with PWM.
- 0x59, then 0xB9 -> {a3,a4,m34_en} goes 101, then 000 for 4 cycles, then 011. A 0x55 during S_RIGHT leaves steering at 011 and drive at STOP.
- In FWD, send nothing for 100 cycles -> wd_timeout pulses once, a1a2m12=000, steering held. Repeat with 0xF9 accepted on the expiry cycle -> no pulse, FWD held.
- duty=0 -> m12_en constantly 0. duty=15 -> m12_en constantly 1. A duty change mid-period takes effect only at counter wrap.
- Assert reset during D_DEAD -> all pins 0 immediately. Send 0x79 after release -> a1a2=01 with no dead time.

Source files
------------

// File: rtl/motor_cmd_sequencer.sv
// rtl/motor_cmd_sequencer.sv - command-driven H-bridge sequencer with dead time, PWM and watchdog
//
// Decodes command bytes into independent drive and steering bridge FSMs.
// Every polarity reversal passes through a dead state with all pins low.
// The drive enable is PWM-modulated.
// A watchdog forces the drive to stop when no command is accepted for too long.
//
// Optional build macro: MOTOR_BRAKE_EN
//   When defined, D_STOP shorts the drive bridge (a1=a2=m12_en=1).
//   When not defined, D_STOP coasts (all drive pins 0).
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   cmd_data   in   command byte
//   cmd_valid  in   cmd_data valid
//   cmd_ready  out  command can be accepted (low while either bridge is in dead time)
//   duty       in   drive duty cycle, sampled at PWM counter wrap
//   a1, a2     out  drive bridge polarity (FWD=10, REV=01)
//   m12_en     out  drive bridge enable (PWM)
//   a3, a4     out  steering bridge polarity (LEFT=10, RIGHT=01)
//   m34_en     out  steering bridge enable
//   wd_timeout out  one-cycle pulse when the watchdog fires
module motor_cmd_sequencer #(
  parameter int DEADTIME_CYCLES = 1000,
  parameter int WATCHDOG_CYCLES = 5000000,
  parameter int PWM_BITS        = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          cmd_data,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [PWM_BITS-1:0] duty,
  output logic                a1,
  output logic                a2,
  output logic                m12_en,
  output logic                a3,
  output logic                a4,
  output logic                m34_en,
  output logic                wd_timeout
);

  localparam int DW = $clog2(DEADTIME_CYCLES) + 1;
  localparam int WW = $clog2(WATCHDOG_CYCLES);
  localparam logic [DW-1:0]       DEAD_LAST = DW'(DEADTIME_CYCLES - 1);
  localparam logic [WW-1:0]       WD_LAST   = WW'(WATCHDOG_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;

  typedef enum logic [1:0] {D_STOP, D_FWD, D_REV, D_DEAD} drive_t;
  typedef enum logic [1:0] {S_CENTER, S_LEFT, S_RIGHT, S_DEAD} steer_t;

  drive_t              d_state, d_next, d_tgt, d_tgt_next, drv_cmd;
  steer_t              s_state, s_next, s_tgt, s_tgt_next, str_cmd;
  logic [DW-1:0]       d_cnt, d_cnt_next, s_cnt, s_cnt_next;
  logic [WW-1:0]       wd_cnt, wd_cnt_next;
  logic [PWM_BITS-1:0] pwm_cnt, shadow, eff_duty;
  logic                wd_fire, accept, is_steer, pwm_on;
  logic [2:0]          d_pins;

  assign cmd_ready = (d_state != D_DEAD) && (s_state != S_DEAD);
  assign accept    = cmd_valid && cmd_ready;

  // Steering codes never touch the drive; every non-steering code is a drive command.
  always_comb begin
    drv_cmd  = D_STOP;
    str_cmd  = S_CENTER;
    is_steer = 1'b0;
    case (cmd_data)
      8'hF9:   drv_cmd = D_FWD;
      8'h79:   drv_cmd = D_REV;
      8'h59:   begin is_steer = 1'b1; str_cmd = S_LEFT;   end
      8'hE9:   begin is_steer = 1'b1; str_cmd = S_CENTER; end
      8'hB9:   begin is_steer = 1'b1; str_cmd = S_RIGHT;  end
      default: drv_cmd = D_STOP;
    endcase
  end

  // Watchdog saturates at WD_LAST so it fires once per silent period; any accept wins.
  always_comb begin
    wd_cnt_next = wd_cnt;
    wd_fire     = 1'b0;
    if (accept) begin
      wd_cnt_next = '0;
    end else if (wd_cnt != WD_LAST) begin
      wd_cnt_next = wd_cnt + 1'b1;
      wd_fire     = (wd_cnt_next == WD_LAST);
    end
  end

  always_comb begin
    d_next     = d_state;
    d_tgt_next = d_tgt;
    d_cnt_next = d_cnt;
    if (wd_fire) begin
      d_next     = D_STOP;
      d_cnt_next = '0;
    end else if (d_state == D_DEAD) begin
      if (d_cnt == DEAD_LAST) begin
        d_next     = d_tgt;
        d_cnt_next = '0;
      end else begin
        d_cnt_next = d_cnt + 1'b1;
      end
    end else if (accept && !is_steer && (drv_cmd != d_state)) begin
      if ((d_state != D_STOP) && (drv_cmd != D_STOP)) begin
        d_next     = D_DEAD;
        d_tgt_next = drv_cmd;
        d_cnt_next = '0;
      end else begin
        d_next = drv_cmd;
      end
    end
  end

  always_comb begin
    s_next     = s_state;
    s_tgt_next = s_tgt;
    s_cnt_next = s_cnt;
    if (s_state == S_DEAD) begin
      if (s_cnt == DEAD_LAST) begin
        s_next     = s_tgt;
        s_cnt_next = '0;
      end else begin
        s_cnt_next = s_cnt + 1'b1;
      end
    end else if (accept && is_steer && (str_cmd != s_state)) begin
      if ((s_state != S_CENTER) && (str_cmd != S_CENTER)) begin
        s_next     = S_DEAD;
        s_tgt_next = str_cmd;
        s_cnt_next = '0;
      end else begin
        s_next = str_cmd;
      end
    end
  end

  // At counter 0 the shadow is being reloaded, so compare against the incoming duty
  // to keep the whole period on one duty value.
  always_comb begin
    eff_duty = (pwm_cnt == '0) ? duty : shadow;
    pwm_on   = (eff_duty == DUTY_FULL) || (pwm_cnt < eff_duty);
  end

  always_comb begin
    d_pins = 3'b000;
    case (d_state)
      D_FWD:  d_pins = {2'b10, pwm_on};
      D_REV:  d_pins = {2'b01, pwm_on};
`ifdef MOTOR_BRAKE_EN
      D_STOP: d_pins = 3'b111;
`else
      D_STOP: d_pins = 3'b000;
`endif
      default: d_pins = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_state    <= D_STOP;
      d_tgt      <= D_STOP;
      d_cnt      <= '0;
      s_state    <= S_CENTER;
      s_tgt      <= S_CENTER;
      s_cnt      <= '0;
      wd_cnt     <= '0;
      pwm_cnt    <= '0;
      shadow     <= '0;
      wd_timeout <= 1'b0;
      a1         <= 1'b0;
      a2         <= 1'b0;
      m12_en     <= 1'b0;
      a3         <= 1'b0;
      a4         <= 1'b0;
      m34_en     <= 1'b0;
    end else begin
      d_state    <= d_next;
      d_tgt      <= d_tgt_next;
      d_cnt      <= d_cnt_next;
      s_state    <= s_next;
      s_tgt      <= s_tgt_next;
      s_cnt      <= s_cnt_next;
      wd_cnt     <= wd_cnt_next;
      pwm_cnt    <= pwm_cnt + 1'b1;
      if (pwm_cnt == '0) shadow <= duty;
      wd_timeout <= wd_fire;
      // Pins follow the current state one edge later, which also gives exactly
      // DEADTIME_CYCLES cycles of 00 per dead period.
      {a1, a2, m12_en} <= d_pins;
      a3         <= (s_state == S_LEFT);
      a4         <= (s_state == S_RIGHT);
      m34_en     <= (s_state == S_LEFT) || (s_state == S_RIGHT);
    end
  end

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// tb/tb_motor_cmd_sequencer.sv - self-checking bench for motor_cmd_sequencer
module tb_motor_cmd_sequencer;

  localparam int D    = 4;
  localparam int W    = 100;
  localparam int B    = 4;
  localparam int PMAX = (1 << B) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   cmd_data = 8'h00;
  logic         cmd_valid = 1'b0;
  logic [B-1:0] duty = '0;
  logic         cmd_ready, a1, a2, m12_en, a3, a4, m34_en, wd_timeout;

  motor_cmd_sequencer #(
    .DEADTIME_CYCLES(D),
    .WATCHDOG_CYCLES(W),
    .PWM_BITS(B)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_data(cmd_data),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .duty(duty),
    .a1(a1),
    .a2(a2),
    .m12_en(m12_en),
    .a3(a3),
    .a4(a4),
    .m34_en(m34_en),
    .wd_timeout(wd_timeout)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: modes 0=stop/center, 1=fwd/left, 2=rev/right.
  // A nonzero *_dead is the number of dead cycles still to run.
  int         m_drive, m_dtgt, m_ddead, m_steer, m_stgt, m_sdead, m_wd, m_phase, m_sh;
  logic [6:0] exp_pins;   // {a1,a2,m12_en,a3,a4,m34_en,wd_timeout}
  logic       exp_ready;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_drive = 0; m_dtgt = 0; m_ddead = 0;
    m_steer = 0; m_stgt = 0; m_sdead = 0;
    m_wd = 0; m_phase = 0; m_sh = 0;
    exp_pins = '0;
    exp_ready = 1'b1;
  endtask

  task automatic model_edge();
    bit rdy, acc, on, fire;
    int dc, sc;
    rdy = (m_ddead == 0) && (m_sdead == 0);
    acc = cmd_valid && rdy;
    dc = -1;
    sc = -1;
    case (cmd_data)
      8'hF9:   dc = 1;
      8'h79:   dc = 2;
      8'h59:   sc = 1;
      8'hE9:   sc = 0;
      8'hB9:   sc = 2;
      default: dc = 0;
    endcase
    if (m_phase == 0) m_sh = int'(duty);
    on = (m_sh == PMAX) || (m_phase < m_sh);
    m_phase = (m_phase + 1) % (PMAX + 1);
    exp_pins[6] = (m_ddead == 0) && (m_drive == 1);
    exp_pins[5] = (m_ddead == 0) && (m_drive == 2);
    exp_pins[4] = (m_ddead == 0) && (m_drive != 0) && on;
    exp_pins[3] = (m_sdead == 0) && (m_steer == 1);
    exp_pins[2] = (m_sdead == 0) && (m_steer == 2);
    exp_pins[1] = (m_sdead == 0) && (m_steer != 0);
    fire = 1'b0;
    if (acc) m_wd = 0;
    else if (m_wd < W - 1) begin
      m_wd++;
      fire = (m_wd == W - 1);
    end
    exp_pins[0] = fire;
    if (fire) begin
      m_drive = 0;
      m_ddead = 0;
    end else if (m_ddead > 0) begin
      if (m_ddead == 1) m_drive = m_dtgt;
      m_ddead--;
    end else if (acc && dc >= 0 && dc != m_drive) begin
      if (m_drive != 0 && dc != 0) begin
        m_dtgt = dc;
        m_ddead = D;
      end else m_drive = dc;
    end
    if (m_sdead > 0) begin
      if (m_sdead == 1) m_steer = m_stgt;
      m_sdead--;
    end else if (acc && sc >= 0 && sc != m_steer) begin
      if (m_steer != 0 && sc != 0) begin
        m_stgt = sc;
        m_sdead = D;
      end else m_steer = sc;
    end
    exp_ready = (m_ddead == 0) && (m_sdead == 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("pins", {a1, a2, m12_en, a3, a4, m34_en, wd_timeout}, exp_pins);
    chk("cmd_ready", cmd_ready, exp_ready);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(logic [7:0] data);
    cmd_data = data;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int hi, zc, rc, wp, r;
    model_reset();
    duty = 4'd8;
    repeat (2) @(negedge clk);
    chk("reset_pins", {a1, a2, m12_en, a3, a4, m34_en, wd_timeout}, 7'b0);
    chk("reset_ready", cmd_ready, 1'b1);
    reset = 1'b0;

    // Forward at duty 8: 8 of 16 cycles high, ready stays high.
    send(8'hF9);
    run(24);
    hi = 0; rc = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      hi += m12_en;
      rc += cmd_ready;
    end
    chk("pwm_duty8", hi, 8);
    chk("fwd_ready", rc, 16);
    chk("fwd_pins", {a1, a2}, 2'b10);

    // Reversal: exactly D cycles of 00 with ready low.
    send(8'h79);
    zc = 0;
    rc = (cmd_ready == 1'b0);
    for (int i = 0; i < 12; i++) begin
      step();
      zc += ({a1, a2} == 2'b00);
      rc += (cmd_ready == 1'b0);
    end
    chk("drive_dead_len", zc, D);
    chk("drive_ready_low", rc, D);
    chk("rev_pins", {a1, a2}, 2'b01);

    // Steering left, then right through dead time, then an unknown code.
    send(8'h59);
    run(3);
    chk("steer_left", {a3, a4, m34_en}, 3'b101);
    send(8'hB9);
    zc = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      zc += ({a3, a4, m34_en} == 3'b000);
    end
    chk("steer_dead_len", zc, D);
    chk("steer_right", {a3, a4, m34_en}, 3'b011);
    send(8'h55);
    run(3);
    chk("unknown_steer", {a3, a4, m34_en}, 3'b011);
    chk("unknown_drive", {a1, a2, m12_en}, 3'b000);

    // Watchdog expiry from FWD.
    send(8'hF9);
    wp = 0;
    for (int i = 0; i < 110; i++) begin
      step();
      wp += wd_timeout;
    end
    chk("wd_pulses", wp, 1);
    chk("wd_drive", {a1, a2, m12_en}, 3'b000);
    chk("wd_steer", {a3, a4, m34_en}, 3'b011);

    // Command accepted on the expiry edge wins.
    send(8'hF9);
    for (int i = 0; i < 200 && m_wd != W - 2; i++) step();
    send(8'hF9);
    chk("wd_preempt", wd_timeout, 1'b0);
    step();
    chk("wd_preempt_fwd", {a1, a2}, 2'b10);

    // Duty extremes.
    duty = 4'd0;
    send(8'hF9);
    run(24);
    hi = 0;
    for (int i = 0; i < 16; i++) begin step(); hi += m12_en; end
    chk("pwm_duty0", hi, 0);
    duty = 4'd15;
    send(8'hF9);
    run(24);
    hi = 0;
    for (int i = 0; i < 16; i++) begin step(); hi += m12_en; end
    chk("pwm_duty15", hi, 16);

    // Mid-period duty change only lands at the wrap.
    duty = 4'd4;
    send(8'hF9);
    run(16);
    for (int i = 0; i < 20 && m_phase != 5; i++) step();
    duty = 4'd12;
    hi = 0;
    for (int i = 0; i < 5; i++) begin step(); hi += m12_en; end
    chk("pwm_mid_hold", hi, 0);
    for (int i = 0; i < 20 && m_phase != 0; i++) step();
    hi = 0;
    for (int i = 0; i < 16; i++) begin step(); hi += m12_en; end
    chk("pwm_after_wrap", hi, 12);

    // Reset during drive dead time.
    send(8'h79);
    run(2);
    reset = 1'b1;
    #1;
    chk("async_reset_pins", {a1, a2, m12_en, a3, a4, m34_en, wd_timeout}, 7'b0);
    chk("async_reset_ready", cmd_ready, 1'b1);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send(8'h79);
    step();
    chk("post_reset_rev", {a1, a2}, 2'b01);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 5);
      case (r)
        0: cmd_data = 8'hF9;
        1: cmd_data = 8'h79;
        2: cmd_data = 8'h59;
        3: cmd_data = 8'hE9;
        4: cmd_data = 8'hB9;
        default: cmd_data = 8'($urandom);
      endcase
      if ($urandom_range(0, 31) == 0) duty = B'($urandom);
      step();
    end
    cmd_valid = 1'b0;
    run(150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
